jt49_bus_arb: RTL and testbench
===============================

# jt49_bus_arb

Two-port arbiter and bus-cycle sequencer for the BDIR/BC1 PSG bus wrapper. It accepts register read/write requests from two independent requesters, such as a CPU-side port and a music/effects player. Grants are round-robin. Each granted access becomes a legal AY-style pin sequence: address latch (BDIR/BC1=11), gap, data phase (10 write / 01 read), gap. The block sits between the requesters and the PSG bus wrapper's `bdir`/`bc1`/`din`/`dout` pins.

## Interface
- `HOLD`, 2: cycles each address/data phase is held; legal 1..15. Set it at or above the PSG clock-enable period.
- `clk` input 1: system clock, positive edge.
- `rst` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1: request per port; held high until the matching ack.
- `rnw0`, `rnw1` input 1: 1 = read, 0 = write.
- `addr0`, `addr1` input 4: PSG register number.
- `wdata0`, `wdata1` input 8: write data.
- `ack0`, `ack1` output 1: one-cycle completion pulse per port.
- `rdata` output 8: read result, valid while the ack is high.
- `busy` output 1: high in every state except IDLE.
- `bdir`, `bc1` output 1: PSG bus control pins.
- `psg_din` output 8: data/address presented to the PSG.
- `psg_dout` input 8: PSG read-back data.

## Operation
- FSM states: IDLE, ADDR, GAP1, DATA, END. All outputs are registered.
- **IDLE:** `bdir,bc1`=00 and `psg_din`=0.
  - If any request is high, grant one port, latch its rnw/addr/wdata, and go to ADDR.
- **ADDR:** 11, with `psg_din`={4'h0,addr}. Held for HOLD cycles, then GAP1.
- **GAP1:** 00 for 1 cycle, then DATA.
- **DATA, write:** 10, with `psg_din`=wdata. Held for HOLD cycles.
- **DATA, read:** 01, with `psg_din`=0. Held for HOLD cycles.
  - `rdata` captures `psg_dout` on the last DATA cycle.
- **END:** 00 for 1 cycle. The granted port's ack is high for this cycle only. Then IDLE.
- **Arbitration:** round-robin on `last` (the last-granted port). Reset value is `last`=1, so port 0 wins first.
  - Both ports requesting: grant the port that is not `last`.
  - Single request: grant it regardless of `last`.
- Request fields are sampled only at grant. Later changes, including req dropping mid-access, are ignored and the access completes normally.
- A 4-bit phase counter counts HOLD-1 down to 0.
- Reset mid-access: the next cycle is IDLE with all outputs cleared. No ack is issued and the pending access is abandoned.
- **Reset values:** `bdir`=`bc1`=0, `psg_din`=0, `ack0`=`ack1`=0, `rdata`=0, `busy`=0, `last`=1.

## Timing
- Let cycle 0 be the IDLE cycle whose closing edge samples the req.
  - ADDR occupies cycles 1..HOLD.
  - GAP1 is cycle HOLD+1.
  - DATA occupies cycles HOLD+2..2·HOLD+1.
  - END and the ack fall in cycle 2·HOLD+2.
- Request-to-ack latency is 2·HOLD+2 cycles. Minimum access spacing is 2·HOLD+3 cycles, because one IDLE cycle always separates accesses.
- A requester drops req on the edge that ends its ack cycle. The following IDLE cycle therefore cannot re-grant the same access.
- `rdata` holds its value until the next read completes.

## Configuration
- Macro: `JT49_ARB_ADDR_CACHE_EN`.
- **Defined:**
  - A valid/addr register tracks the PSG's latched address.
  - On grant, if the cache is valid and the granted addr equals the cached addr, skip ADDR and GAP1 and go straight to DATA. Latency becomes HOLD+1.
  - Every completed ADDR phase sets valid and records the address.
  - Reset clears valid.
- **Undefined:** every access runs the ADDR phase, and there is no cache logic.

## Test plan
- **Single write:** HOLD=2; port 0 writes addr=7, data=0x38.
  - bdir,bc1 = 11,11,00,10,10,00.
  - `psg_din` = 0x07 during 11 and 0x38 during 10.
  - `ack0` in cycle 6.
- **Read:** port 1 reads addr=14 with `psg_dout`=0xA5.
  - bdir,bc1 = 11,11,00,01,01.
  - `ack1` with `rdata`=0xA5 in cycle 6.
- **Contention:** both ports request from reset.
  - Grant order 0,1,0,1.
  - Acks are spaced 7 cycles apart at HOLD=2.
- **Reset mid-access:** assert `rst` during DATA.
  - Next cycle: bdir,bc1=00, no ack, `busy`=0.
  - A new req is then granted to port 0.
- **HOLD=1 boundary:** sequence 11,00,10,00; ack at cycle 4.
- **With `JT49_ARB_ADDR_CACHE_EN`:**
  - Two writes to addr=8: the second shows no 11 phase and acks 3 cycles after grant.
  - A write to addr=9 afterwards restores the 11 phase.

Source files
------------

// File: rtl/jt49_bus_arb.sv
// Round-robin two-port arbiter driving AY-style BDIR/BC1 bus cycles.
// Optional address cache: define JT49_ARB_ADDR_CACHE_EN.
module jt49_bus_arb #(
    parameter int HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rnw0,
    input  logic       rnw1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] psg_din,
    input  logic [7:0] psg_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_END
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(HOLD - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       gnt;
    logic       last;
    logic       rnw;
    logic [3:0] addr;
    logic [7:0] wdata;

    logic       gnt1;
    logic       sel_rnw;
    logic [3:0] sel_addr;
    logic [7:0] sel_wdata;
    logic       hit;

    // Port 1 wins only when alone or when port 0 had the last grant
    assign gnt1      = req1 & (~req0 | ~last);
    assign sel_rnw   = gnt1 ? rnw1   : rnw0;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

`ifdef JT49_ARB_ADDR_CACHE_EN
    logic       cache_vld;
    logic [3:0] cache_addr;

    assign hit = cache_vld && (cache_addr == sel_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld  <= 1'b0;
            cache_addr <= 4'h0;
        end else if (state == S_ADDR && cnt == 4'd0) begin
            cache_vld  <= 1'b1;
            cache_addr <= addr;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            gnt     <= 1'b0;
            last    <= 1'b1;
            rnw     <= 1'b0;
            addr    <= 4'h0;
            wdata   <= 8'h00;
            bdir    <= 1'b0;
            bc1     <= 1'b0;
            psg_din <= 8'h00;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata   <= 8'h00;
            busy    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        gnt   <= gnt1;
                        last  <= gnt1;
                        rnw   <= sel_rnw;
                        addr  <= sel_addr;
                        wdata <= sel_wdata;
                        busy  <= 1'b1;
                        cnt   <= CNT_INIT;
                        if (hit) begin
                            state   <= S_DATA;
                            bdir    <= ~sel_rnw;
                            bc1     <= sel_rnw;
                            psg_din <= sel_rnw ? 8'h00 : sel_wdata;
                        end else begin
                            state   <= S_ADDR;
                            bdir    <= 1'b1;
                            bc1     <= 1'b1;
                            psg_din <= {4'h0, sel_addr};
                        end
                    end
                end
                S_ADDR: begin
                    if (cnt == 4'd0) begin
                        state   <= S_GAP1;
                        bdir    <= 1'b0;
                        bc1     <= 1'b0;
                        psg_din <= 8'h00;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_GAP1: begin
                    state   <= S_DATA;
                    cnt     <= CNT_INIT;
                    bdir    <= ~rnw;
                    bc1     <= rnw;
                    psg_din <= rnw ? 8'h00 : wdata;
                end
                S_DATA: begin
                    if (cnt == 4'd0) begin
                        state   <= S_END;
                        bdir    <= 1'b0;
                        bc1     <= 1'b0;
                        psg_din <= 8'h00;
                        ack0    <= ~gnt;
                        ack1    <= gnt;
                        if (rnw) begin
                            rdata <= psg_dout;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt49_bus_arb.sv
// Directed-vector bench for jt49_bus_arb (HOLD=2 main instance, HOLD=1 boundary).
// Cache checks follow JT49_ARB_ADDR_CACHE_EN.
module tb_jt49_bus_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, rnw0, rnw1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1, psg_dout;
    logic       ack0, ack1, busy, bdir, bc1;
    logic [7:0] rdata, psg_din;

    logic       h1_req0;
    logic       h1_ack0, h1_ack1, h1_busy, h1_bdir, h1_bc1;
    logic [7:0] h1_rdata, h1_din;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jt49_bus_arb #(.HOLD(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rnw0(rnw0), .rnw1(rnw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .bdir(bdir), .bc1(bc1), .psg_din(psg_din), .psg_dout(psg_dout)
    );

    jt49_bus_arb #(.HOLD(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(h1_req0), .req1(1'b0), .rnw0(rnw0), .rnw1(1'b0),
        .addr0(addr0), .addr1(4'h0), .wdata0(wdata0), .wdata1(8'h00),
        .ack0(h1_ack0), .ack1(h1_ack1), .rdata(h1_rdata), .busy(h1_busy),
        .bdir(h1_bdir), .bc1(h1_bc1), .psg_din(h1_din), .psg_dout(8'h00)
    );

    typedef struct {
        logic       rst, q0, q1, rw0, rw1;
        logic [3:0] a0, a1;
        logic [7:0] w0, w1, dout;
        logic [1:0] pins;
        logic [7:0] din;
        logic       k0, k1, bsy;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, q0, q1, rw0, rw1,
        input logic [3:0] a0, a1,
        input logic [7:0] w0, w1, dout,
        input logic [1:0] pins,
        input logic [7:0] din,
        input logic k0, k1, bsy,
        input logic [7:0] rd
    );
        vec_t v;
        v.rst = r; v.q0 = q0; v.q1 = q1; v.rw0 = rw0; v.rw1 = rw1;
        v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1; v.dout = dout;
        v.pins = pins; v.din = din; v.k0 = k0; v.k1 = k1; v.bsy = bsy;
        v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; h1_req0 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Port-0 write on the HOLD=2 instance; seq holds pin codes, first at MSB
    task automatic access0(input string name, input logic [3:0] a,
                           input logic [7:0] d, input int n,
                           input logic [15:0] seq);
        logic [1:0] code;
        logic [7:0] edin;
        req0 = 1'b1; rnw0 = 1'b0; addr0 = a; wdata0 = d;
        for (int i = 1; i <= n; i++) begin
            tick();
            code = seq[15 - 2 * (i - 1) -: 2];
            edin = (code == 2'b11) ? {4'h0, a} :
                   (code == 2'b10) ? d : 8'h00;
            chk($sformatf("%s_c%0d", name, i),
                32'({bdir, bc1, psg_din, ack0}),
                32'({code, edin, (i == n)}));
        end
        req0 = 1'b0;
        tick();
    endtask

    initial begin
        int k;
        int got;
        logic [1:0] p1 [4];
        logic [7:0] d1 [4];

        rst = 1'b1; req0 = 0; req1 = 0; rnw0 = 0; rnw1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; psg_dout = 0;
        h1_req0 = 0;

        // Single write, port 0, addr 7, data 0x38
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 2'b00,8'h00,0,0,0,8'h00));
        vecs.push_back(mk(0,1,0,0,0,7,0,8'h38,0,0, 2'b11,8'h07,0,0,1,8'h00));
        vecs.push_back(mk(0,1,0,0,0,7,0,8'h38,0,0, 2'b11,8'h07,0,0,1,8'h00));
        vecs.push_back(mk(0,1,0,0,0,7,0,8'h38,0,0, 2'b00,8'h00,0,0,1,8'h00));
        vecs.push_back(mk(0,1,0,0,0,7,0,8'h38,0,0, 2'b10,8'h38,0,0,1,8'h00));
        vecs.push_back(mk(0,1,0,0,0,7,0,8'h38,0,0, 2'b10,8'h38,0,0,1,8'h00));
        vecs.push_back(mk(0,1,0,0,0,7,0,8'h38,0,0, 2'b00,8'h00,1,0,1,8'h00));
        vecs.push_back(mk(0,1,0,0,0,7,0,8'h38,0,0, 2'b00,8'h00,0,0,0,8'h00));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 2'b00,8'h00,0,0,0,8'h00));
        // Read, port 1, addr 14, PSG returns 0xA5
        vecs.push_back(mk(0,0,1,0,1,0,14,0,0,8'hA5, 2'b11,8'h0E,0,0,1,8'h00));
        vecs.push_back(mk(0,0,1,0,1,0,14,0,0,8'hA5, 2'b11,8'h0E,0,0,1,8'h00));
        vecs.push_back(mk(0,0,1,0,1,0,14,0,0,8'hA5, 2'b00,8'h00,0,0,1,8'h00));
        vecs.push_back(mk(0,0,1,0,1,0,14,0,0,8'hA5, 2'b01,8'h00,0,0,1,8'h00));
        vecs.push_back(mk(0,0,1,0,1,0,14,0,0,8'hA5, 2'b01,8'h00,0,0,1,8'h00));
        vecs.push_back(mk(0,0,1,0,1,0,14,0,0,8'hA5, 2'b00,8'h00,0,1,1,8'hA5));
        vecs.push_back(mk(0,0,1,0,1,0,14,0,0,8'hA5, 2'b00,8'h00,0,0,0,8'hA5));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,8'h00, 2'b00,8'h00,0,0,0,8'hA5));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req0 = vecs[i].q0; req1 = vecs[i].q1;
            rnw0 = vecs[i].rw0; rnw1 = vecs[i].rw1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1;
            wdata0 = vecs[i].w0; wdata1 = vecs[i].w1;
            psg_dout = vecs[i].dout;
            tick();
            chk($sformatf("vec%0d", i),
                32'({bdir, bc1, psg_din, ack0, ack1, busy, rdata}),
                32'({vecs[i].pins, vecs[i].din, vecs[i].k0, vecs[i].k1,
                     vecs[i].bsy, vecs[i].rd}));
        end

        // Contention from reset: grants alternate 0,1,0,1 seven cycles apart
        do_reset();
        rnw0 = 0; rnw1 = 0; addr0 = 3; addr1 = 5;
        wdata0 = 8'h11; wdata1 = 8'h22;
        req0 = 1; req1 = 1;
        k = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ack0 | ack1) begin
                chk($sformatf("cont_ack%0d", k),
                    32'(n * 4 + int'({ack0, ack1})),
                    32'((6 + 7 * k) * 4 + ((k % 2) != 0 ? 1 : 2)));
                k++;
                if (ack0) req0 = 0;
                if (ack1) req1 = 0;
                if (k == 4) break;
            end else begin
                req0 = 1; req1 = 1;
            end
        end
        chk("cont_count", 32'(k), 32'd4);
        req0 = 0; req1 = 0;
        tick();

        // Reset during DATA abandons the access and restores port-0 priority
        do_reset();
        rnw0 = 0; addr0 = 2; wdata0 = 8'h44; req0 = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_pre_data", 32'({bdir, bc1, psg_din}), 32'({2'b10, 8'h44}));
        rst = 1; req0 = 0;
        tick();
        rst = 0;
        chk("rst_cleared", 32'({bdir, bc1, ack0, ack1, busy}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rst_idle%0d", i),
                32'({bdir, bc1, ack0, ack1, busy}), 32'd0);
        end
        addr0 = 4; addr1 = 6; rnw1 = 0; req0 = 1; req1 = 1;
        got = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (ack0 | ack1) begin
                chk("rst_regrant", 32'(n * 4 + int'({ack0, ack1})),
                    32'(6 * 4 + 2));
                got = 1;
                break;
            end
        end
        chk("rst_regrant_seen", 32'(got), 32'd1);
        req0 = 0; req1 = 0;
        tick();
        tick();

        // HOLD=1 boundary on the second instance
        do_reset();
        p1[0] = 2'b11; p1[1] = 2'b00; p1[2] = 2'b10; p1[3] = 2'b00;
        d1[0] = 8'h01; d1[1] = 8'h00; d1[2] = 8'h5A; d1[3] = 8'h00;
        rnw0 = 0; addr0 = 1; wdata0 = 8'h5A; h1_req0 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("hold1_c%0d", i + 1),
                32'({h1_bdir, h1_bc1, h1_din, h1_ack0, h1_ack1}),
                32'({p1[i], d1[i], (i == 3), 1'b0}));
        end
        h1_req0 = 0;
        tick();

        // Repeated address: cached builds skip the address phase
        do_reset();
        access0("wr8a", 4'd8, 8'h81, 6, 16'b11_11_00_10_10_00_00_00);
`ifdef JT49_ARB_ADDR_CACHE_EN
        access0("wr8b", 4'd8, 8'h82, 3, 16'b10_10_00_00_00_00_00_00);
`else
        access0("wr8b", 4'd8, 8'h82, 6, 16'b11_11_00_10_10_00_00_00);
`endif
        access0("wr9", 4'd9, 8'h93, 6, 16'b11_11_00_10_10_00_00_00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
